// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the RV32I execute stage.
//   - ALU operation codes
//   - ALU operand source selects
//   - writeback source and jump type encodings
//   - forwarding select values
//   - branch funct3 values
//   - ctrl_t: control bundle carried through the ID/EX register
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_sel_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'd0,
        JUMP_JAL  = 2'd1,
        JUMP_JALR = 2'd2
    } jump_e;

    typedef enum logic [2:0] {
        FWD_NONE = 3'd0,
        FWD_MEM  = 3'd1,
        FWD_WB   = 3'd2
    } fwd_sel_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_funct3_e;

    // All-zero value is a NOP: no write, no store, no branch, no jump.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       meet_branch;
        logic [1:0] result_sel;
        logic [1:0] uncond_jump;
        logic [3:0] alu_ctrl;
        logic [1:0] alu_sel_rs1;
        logic [1:0] alu_sel_rs2;
        logic [2:0] funct3;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the execute stage's ID-side inputs, forwarding
// inputs, combinational EX outputs and registered EX/MEM outputs.
//   master: driven by the surrounding pipeline (ID, forwarding unit)
//   slave : the execute stage itself
interface ex_stage_if #(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
);
    // ID side
    logic                           flush_ID_EX;
    logic [INST_ADDR_WIDTH-1:0]     PC_ID, PC_plus_4_ID;
    logic [INST_WIDTH-1:0]          INST_ID;
    logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID, rs2_ID, rd_ID;
    logic [DATA_WIDTH-1:0]          imm_ID, RD1D_ID, RD2D_ID;
    logic                           reg_write_ID, mem_write_ID, meet_branch_ID;
    logic [1:0]                     result_sel_ID, uncond_jump_ID;
    logic [3:0]                     alu_ctrl_ID;
    logic [1:0]                     alu_sel_rs1_ID, alu_sel_rs2_ID;
    logic [2:0]                     funct3_ID;

    // Forwarding
    logic [2:0]                     forward_detect_EX_rs1, forward_detect_EX_rs2;
    logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o_fwd, result_WB;

    // Combinational EX outputs
    logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX, rs2_EX, rd_EX;
    logic [1:0]                     result_sel_EX;
    logic                           PC_take_branch_EX, PC_take_jalr_EX;
    logic [INST_ADDR_WIDTH-1:0]     PC_for_normal_branch_EX, PC_for_jalr_EX;

    // Registered EX/MEM outputs
    logic [INST_WIDTH-1:0]          INST_EX_MEM_o;
    logic                           reg_write_EX_MEM_o, mem_write_EX_MEM_o;
    logic [1:0]                     result_sel_EX_MEM_o;
    logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o;
    logic [DATA_WIDTH-1:0]          write_data_EX_MEM_o;
    logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o;
    logic [2:0]                     funct3_EX_MEM_o;

    modport master (
        output flush_ID_EX, PC_ID, PC_plus_4_ID, INST_ID, rs1_ID, rs2_ID, rd_ID,
               imm_ID, RD1D_ID, RD2D_ID, reg_write_ID, mem_write_ID, meet_branch_ID,
               result_sel_ID, uncond_jump_ID, alu_ctrl_ID, alu_sel_rs1_ID,
               alu_sel_rs2_ID, funct3_ID,
               forward_detect_EX_rs1, forward_detect_EX_rs2,
               alu_res_EX_MEM_o_fwd, result_WB,
        input  rs1_EX, rs2_EX, rd_EX, result_sel_EX, PC_take_branch_EX,
               PC_take_jalr_EX, PC_for_normal_branch_EX, PC_for_jalr_EX,
               INST_EX_MEM_o, reg_write_EX_MEM_o, mem_write_EX_MEM_o,
               result_sel_EX_MEM_o, alu_res_EX_MEM_o, rd_EX_MEM_o,
               write_data_EX_MEM_o, PC_plus_4_EX_MEM_o, funct3_EX_MEM_o
    );

    modport slave (
        input  flush_ID_EX, PC_ID, PC_plus_4_ID, INST_ID, rs1_ID, rs2_ID, rd_ID,
               imm_ID, RD1D_ID, RD2D_ID, reg_write_ID, mem_write_ID, meet_branch_ID,
               result_sel_ID, uncond_jump_ID, alu_ctrl_ID, alu_sel_rs1_ID,
               alu_sel_rs2_ID, funct3_ID,
               forward_detect_EX_rs1, forward_detect_EX_rs2,
               alu_res_EX_MEM_o_fwd, result_WB,
        output rs1_EX, rs2_EX, rd_EX, result_sel_EX, PC_take_branch_EX,
               PC_take_jalr_EX, PC_for_normal_branch_EX, PC_for_jalr_EX,
               INST_EX_MEM_o, reg_write_EX_MEM_o, mem_write_EX_MEM_o,
               result_sel_EX_MEM_o, alu_res_EX_MEM_o, rd_EX_MEM_o,
               write_data_EX_MEM_o, PC_plus_4_EX_MEM_o, funct3_EX_MEM_o
    );

endinterface

// File: rtl/ex_stage_alu.sv
// alu: RV32I integer ALU.
//   a, b   : operands
//   ctrl   : operation (alu_op_e); unknown codes give 0
//   result : wraps modulo 2^DATA_WIDTH; shifts use b[4:0]
module alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            ctrl,
    output logic [DATA_WIDTH-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage RV32I pipeline.
//   ID/EX register -> forwarding, operand muxes, ALU, branch/jump
//   resolution -> EX/MEM register.
// Ports:
//   cpu_clk   : rising-edge clock
//   cpu_rst_n : asynchronous active-low reset, clears both registers
//   bus       : ex_stage_if.slave (ID inputs, forwarding inputs,
//               combinational EX outputs, registered EX/MEM outputs)
// Build option:
//   EX_RS2_FWD_EN : when defined, rs2 honours forward_detect_EX_rs2;
//                   otherwise rs2 always uses the registered RD2D.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_ADDR_WIDTH     = 32,
    parameter int REGISTER_WIDTH      = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input logic       cpu_clk,
    input logic       cpu_rst_n,
    ex_stage_if.slave bus
);

    // The datapath treats register contents and data addresses as
    // DATA_WIDTH values; other combinations are not supported.
    if (REGISTER_WIDTH != DATA_WIDTH || DATA_ADDR_WIDTH > DATA_WIDTH) begin : g_unsupported_widths
    end

    // ---------------- ID/EX register ----------------
    logic [INST_ADDR_WIDTH-1:0]     pc_ex, pc4_ex;
    logic [INST_WIDTH-1:0]          inst_ex;
    logic [REGISTER_ADDR_WIDTH-1:0] rs1_ex, rs2_ex, rd_ex;
    logic [DATA_WIDTH-1:0]          imm_ex, rd1_ex, rd2_ex;
    ctrl_t                          ctrl_id, ctrl_ex;

    assign ctrl_id = '{
        reg_write:   bus.reg_write_ID,
        mem_write:   bus.mem_write_ID,
        meet_branch: bus.meet_branch_ID,
        result_sel:  bus.result_sel_ID,
        uncond_jump: bus.uncond_jump_ID,
        alu_ctrl:    bus.alu_ctrl_ID,
        alu_sel_rs1: bus.alu_sel_rs1_ID,
        alu_sel_rs2: bus.alu_sel_rs2_ID,
        funct3:      bus.funct3_ID
    };

    // Flush loads the all-zero bubble, which decodes as a NOP.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n || bus.flush_ID_EX) begin
            pc_ex   <= '0;
            pc4_ex  <= '0;
            inst_ex <= '0;
            rs1_ex  <= '0;
            rs2_ex  <= '0;
            rd_ex   <= '0;
            imm_ex  <= '0;
            rd1_ex  <= '0;
            rd2_ex  <= '0;
            ctrl_ex <= '0;
        end else begin
            pc_ex   <= bus.PC_ID;
            pc4_ex  <= bus.PC_plus_4_ID;
            inst_ex <= bus.INST_ID;
            rs1_ex  <= bus.rs1_ID;
            rs2_ex  <= bus.rs2_ID;
            rd_ex   <= bus.rd_ID;
            imm_ex  <= bus.imm_ID;
            rd1_ex  <= bus.RD1D_ID;
            rd2_ex  <= bus.RD2D_ID;
            ctrl_ex <= ctrl_id;
        end
    end

    // ---------------- Forwarding ----------------
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

    always_comb begin
        case (bus.forward_detect_EX_rs1)
            FWD_MEM: rs1_val = bus.alu_res_EX_MEM_o_fwd;
            FWD_WB:  rs1_val = bus.result_WB;
            default: rs1_val = rd1_ex;
        endcase
    end

`ifdef EX_RS2_FWD_EN
    always_comb begin
        case (bus.forward_detect_EX_rs2)
            FWD_MEM: rs2_val = bus.alu_res_EX_MEM_o_fwd;
            FWD_WB:  rs2_val = bus.result_WB;
            default: rs2_val = rd2_ex;
        endcase
    end
`else
    logic unused_fwd_rs2;
    assign unused_fwd_rs2 = ^bus.forward_detect_EX_rs2;
    assign rs2_val        = rd2_ex;
`endif

    // ---------------- Operand muxes + ALU ----------------
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_res;

    always_comb begin
        case (ctrl_ex.alu_sel_rs1)
            SRC_A_RS1: alu_a = rs1_val;
            SRC_A_PC:  alu_a = DATA_WIDTH'(pc_ex);
            default:   alu_a = '0;
        endcase
        case (ctrl_ex.alu_sel_rs2)
            SRC_B_RS2:  alu_b = rs2_val;
            SRC_B_IMM:  alu_b = imm_ex;
            SRC_B_FOUR: alu_b = DATA_WIDTH'(4);
            default:    alu_b = '0;
        endcase
    end

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (ctrl_ex.alu_ctrl),
        .result (alu_res)
    );

    // ---------------- Branch / jump resolution ----------------
    logic                  br_cond;
    logic [DATA_WIDTH-1:0] jalr_sum;

    always_comb begin
        case (ctrl_ex.funct3)
            BR_EQ:   br_cond = (rs1_val == rs2_val);
            BR_NE:   br_cond = (rs1_val != rs2_val);
            BR_LT:   br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            BR_GE:   br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            BR_LTU:  br_cond = (rs1_val <  rs2_val);
            BR_GEU:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum = rs1_val + imm_ex;

    assign bus.rs1_EX                  = rs1_ex;
    assign bus.rs2_EX                  = rs2_ex;
    assign bus.rd_EX                   = rd_ex;
    assign bus.result_sel_EX           = ctrl_ex.result_sel;
    // JAL shares the PC+imm redirect path with conditional branches.
    assign bus.PC_take_branch_EX       = (ctrl_ex.meet_branch & br_cond)
                                       | (ctrl_ex.uncond_jump == JUMP_JAL);
    assign bus.PC_for_normal_branch_EX = pc_ex + INST_ADDR_WIDTH'(imm_ex);
    assign bus.PC_take_jalr_EX         = (ctrl_ex.uncond_jump == JUMP_JALR);
    assign bus.PC_for_jalr_EX          = INST_ADDR_WIDTH'(jalr_sum) & ~INST_ADDR_WIDTH'(1);

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            bus.INST_EX_MEM_o       <= '0;
            bus.reg_write_EX_MEM_o  <= 1'b0;
            bus.mem_write_EX_MEM_o  <= 1'b0;
            bus.result_sel_EX_MEM_o <= '0;
            bus.alu_res_EX_MEM_o    <= '0;
            bus.rd_EX_MEM_o         <= '0;
            bus.write_data_EX_MEM_o <= '0;
            bus.PC_plus_4_EX_MEM_o  <= '0;
            bus.funct3_EX_MEM_o     <= '0;
        end else begin
            bus.INST_EX_MEM_o       <= inst_ex;
            bus.reg_write_EX_MEM_o  <= ctrl_ex.reg_write;
            bus.mem_write_EX_MEM_o  <= ctrl_ex.mem_write;
            bus.result_sel_EX_MEM_o <= ctrl_ex.result_sel;
            bus.alu_res_EX_MEM_o    <= alu_res;
            bus.rd_EX_MEM_o         <= rd_ex;
            bus.write_data_EX_MEM_o <= rs2_val;
            bus.PC_plus_4_EX_MEM_o  <= pc4_ex;
            bus.funct3_EX_MEM_o     <= ctrl_ex.funct3;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scenarios plus randomized traffic for ex_stage,
// checked against a behavioural model of the execute stage.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.cpu_clk(clk), .cpu_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] pc, pc4, inst, imm, rd1, rd2;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, mb;
        logic [1:0]  rsel, uj, sa, sb;
        logic [3:0]  aluc;
        logic [2:0]  f3;
    } id_t;

    typedef struct {
        logic [31:0] inst, alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rsel;
        logic [2:0]  f3;
    } em_t;

    id_t         id, ex_m;
    em_t         em_m;
    logic        flush;
    logic [2:0]  f1, f2;
    logic [31:0] mem_v, wb_v;
    int          n_vec = 0;
    int          n_err = 0;

    // ---------------- reference model ----------------
    function automatic longint sval(input logic [31:0] x);
        return x[31] ? longint'(x) - 64'sh1_0000_0000 : longint'(x);
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] sel, input logic [31:0] r);
        if (sel == 3'd1) return mem_v;
        if (sel == 3'd2) return wb_v;
        return r;
    endfunction

    function automatic logic [31:0] rs2_model();
`ifdef EX_RS2_FWD_EN
        return pick(f2, ex_m.rd2);
`else
        return ex_m.rd2;
`endif
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        longint sa;
        sh = int'(b % 32);
        sa = sval(a);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return (sa < sval(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_ex(output logic tb, output logic tj, output logic [31:0] tgt_b,
                            output logic [31:0] tgt_j, output logic [31:0] alu, output logic [31:0] wd);
        logic [31:0] r1, r2, a, b;
        logic cond;
        r1 = pick(f1, ex_m.rd1);
        r2 = rs2_model();
        a = (ex_m.sa == 2'd0) ? r1 : (ex_m.sa == 2'd1) ? ex_m.pc : 32'd0;
        b = (ex_m.sb == 2'd0) ? r2 : (ex_m.sb == 2'd1) ? ex_m.imm :
            (ex_m.sb == 2'd2) ? 32'd4 : 32'd0;
        alu = alu_model(ex_m.aluc, a, b);
        case (ex_m.f3)
            3'd0: cond = (r1 == r2);
            3'd1: cond = (r1 != r2);
            3'd4: cond = sval(r1) <  sval(r2);
            3'd5: cond = sval(r1) >= sval(r2);
            3'd6: cond = r1 <  r2;
            3'd7: cond = r1 >= r2;
            default: cond = 1'b0;
        endcase
        tb    = (ex_m.mb && cond) || (ex_m.uj == 2'd1);
        tj    = (ex_m.uj == 2'd2);
        tgt_b = ex_m.pc + ex_m.imm;
        tgt_j = (r1 + ex_m.imm) & 32'hFFFF_FFFE;
        wd    = r2;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive();
        bus.flush_ID_EX = flush;
        bus.PC_ID = id.pc;   bus.PC_plus_4_ID = id.pc4; bus.INST_ID = id.inst;
        bus.rs1_ID = id.rs1; bus.rs2_ID = id.rs2;       bus.rd_ID = id.rd;
        bus.imm_ID = id.imm; bus.RD1D_ID = id.rd1;      bus.RD2D_ID = id.rd2;
        bus.reg_write_ID = id.rw; bus.mem_write_ID = id.mw; bus.meet_branch_ID = id.mb;
        bus.result_sel_ID = id.rsel; bus.uncond_jump_ID = id.uj; bus.alu_ctrl_ID = id.aluc;
        bus.alu_sel_rs1_ID = id.sa; bus.alu_sel_rs2_ID = id.sb; bus.funct3_ID = id.f3;
        bus.forward_detect_EX_rs1 = f1; bus.forward_detect_EX_rs2 = f2;
        bus.alu_res_EX_MEM_o_fwd = mem_v; bus.result_WB = wb_v;
    endtask

    task automatic clear_model();
        ex_m = '{default: '0};
        em_m = '{default: '0};
    endtask

    // One clock: drive current inputs, advance the model at the edge,
    // return at the following falling edge.
    task automatic clk_step();
        logic tb, tj;
        logic [31:0] tgt_b, tgt_j, alu, wd;
        drive();
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            model_ex(tb, tj, tgt_b, tgt_j, alu, wd);
            em_m.inst = ex_m.inst; em_m.rw = ex_m.rw; em_m.mw = ex_m.mw;
            em_m.rsel = ex_m.rsel; em_m.alu = alu;    em_m.rd = ex_m.rd;
            em_m.wd = wd;          em_m.pc4 = ex_m.pc4; em_m.f3 = ex_m.f3;
            if (flush) ex_m = '{default: '0};
            else       ex_m = id;
        end
        @(negedge clk);
    endtask

    function automatic logic [139:0] got_em();
        return {bus.INST_EX_MEM_o, bus.reg_write_EX_MEM_o, bus.mem_write_EX_MEM_o,
                bus.result_sel_EX_MEM_o, bus.alu_res_EX_MEM_o, bus.rd_EX_MEM_o,
                bus.write_data_EX_MEM_o, bus.PC_plus_4_EX_MEM_o, bus.funct3_EX_MEM_o};
    endfunction

    function automatic logic [82:0] got_ex();
        return {bus.rs1_EX, bus.rs2_EX, bus.rd_EX, bus.result_sel_EX,
                bus.PC_take_branch_EX, bus.PC_take_jalr_EX,
                bus.PC_for_normal_branch_EX, bus.PC_for_jalr_EX};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        id = '{default: '0}; flush = 0; f1 = 0; f2 = 0; mem_v = 0; wb_v = 0;
        clear_model();
        rst_n = 1'b0;
        drive();
        #1;
        n_vec++;
        if (got_em() !== 140'd0) begin
            n_err++; $display("FAIL reset_exmem got %h want 0", got_em());
        end
        n_vec++;
        if (got_ex() !== 83'd0) begin
            n_err++; $display("FAIL reset_ex_comb got %h want 0", got_ex());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        id = '{default: '0}; id.rd1 = 32'd5; id.rd2 = 32'd7; id.rw = 1; id.rd = 5'd3;
        clk_step();
        id = '{default: '0};
        n_vec++;
        if (bus.rd_EX !== 5'd3) begin
            n_err++; $display("FAIL add_rd_ex got %0d want 3", bus.rd_EX);
        end
        clk_step();
        n_vec++;
        if (bus.alu_res_EX_MEM_o !== 32'd12 || bus.reg_write_EX_MEM_o !== 1'b1 || bus.rd_EX_MEM_o !== 5'd3) begin
            n_err++; $display("FAIL add_exmem got res=%h rw=%b rd=%0d want 0000000c 1 3",
                              bus.alu_res_EX_MEM_o, bus.reg_write_EX_MEM_o, bus.rd_EX_MEM_o);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] want_res, want_wd;
`ifdef EX_RS2_FWD_EN
        want_res = 32'h0000_00FD; want_wd = 32'd3;
`else
        want_res = 32'h0000_00FF; want_wd = 32'd1;
`endif
        id = '{default: '0}; id.rd1 = 32'h55; id.rd2 = 32'd1; id.aluc = 4'd1;
        clk_step();
        id = '{default: '0};
        f1 = 3'd1; mem_v = 32'h100; f2 = 3'd2; wb_v = 32'd3;
        clk_step();
        f1 = 0; f2 = 0;
        n_vec++;
        if (bus.alu_res_EX_MEM_o !== want_res) begin
            n_err++; $display("FAIL fwd_sub got %h want %h", bus.alu_res_EX_MEM_o, want_res);
        end
        n_vec++;
        if (bus.write_data_EX_MEM_o !== want_wd) begin
            n_err++; $display("FAIL fwd_store_data got %h want %h", bus.write_data_EX_MEM_o, want_wd);
        end
    endtask

    task automatic test_branch();
        id = '{default: '0}; id.rd1 = 32'hFFFF_FFFF; id.rd2 = 32'd1; id.f3 = 3'd4;
        id.mb = 1; id.pc = 32'h40; id.imm = 32'd8;
        clk_step();
        n_vec++;
        if (bus.PC_take_branch_EX !== 1'b1 || bus.PC_for_normal_branch_EX !== 32'h48) begin
            n_err++; $display("FAIL blt_taken got take=%b tgt=%h want 1 00000048",
                              bus.PC_take_branch_EX, bus.PC_for_normal_branch_EX);
        end
        id.f3 = 3'd6;
        clk_step();
        n_vec++;
        if (bus.PC_take_branch_EX !== 1'b0) begin
            n_err++; $display("FAIL bltu_not_taken got %b want 0", bus.PC_take_branch_EX);
        end
        id = '{default: '0}; id.uj = 2'd1; id.pc = 32'h100; id.imm = 32'hFFFF_FFF0;
        clk_step();
        n_vec++;
        if (bus.PC_take_branch_EX !== 1'b1 || bus.PC_for_normal_branch_EX !== 32'hF0) begin
            n_err++; $display("FAIL jal_redirect got take=%b tgt=%h want 1 000000f0",
                              bus.PC_take_branch_EX, bus.PC_for_normal_branch_EX);
        end
    endtask

    task automatic test_jalr();
        id = '{default: '0}; id.rd1 = 32'h1001; id.imm = 32'd4; id.uj = 2'd2;
        id.pc4 = 32'h2004; id.rsel = 2'd2; id.rw = 1;
        clk_step();
        id = '{default: '0};
        n_vec++;
        if (bus.PC_take_jalr_EX !== 1'b1 || bus.PC_for_jalr_EX !== 32'h1004 || bus.PC_take_branch_EX !== 1'b0) begin
            n_err++; $display("FAIL jalr got jalr=%b tgt=%h br=%b want 1 00001004 0",
                              bus.PC_take_jalr_EX, bus.PC_for_jalr_EX, bus.PC_take_branch_EX);
        end
        clk_step();
        n_vec++;
        if (bus.PC_plus_4_EX_MEM_o !== 32'h2004 || bus.result_sel_EX_MEM_o !== 2'd2) begin
            n_err++; $display("FAIL jalr_link got pc4=%h rsel=%0d want 00002004 2",
                              bus.PC_plus_4_EX_MEM_o, bus.result_sel_EX_MEM_o);
        end
    endtask

    task automatic test_flush();
        id = '{default: '0}; id.mw = 1; id.rw = 1; id.rd = 5'd9; id.rd2 = 32'hDEAD;
        flush = 1;
        clk_step();
        flush = 0;
        id = '{default: '0};
        n_vec++;
        if (bus.rd_EX !== 5'd0) begin
            n_err++; $display("FAIL flush_rd_ex got %0d want 0", bus.rd_EX);
        end
        clk_step();
        n_vec++;
        if (bus.mem_write_EX_MEM_o !== 1'b0 || bus.reg_write_EX_MEM_o !== 1'b0) begin
            n_err++; $display("FAIL flush_store got mw=%b rw=%b want 0 0",
                              bus.mem_write_EX_MEM_o, bus.reg_write_EX_MEM_o);
        end
    endtask

    task automatic test_back_to_back_alu();
        id = '{default: '0}; id.rd1 = 32'h8000_0000; id.sb = 2'd1; id.imm = 32'd4; id.aluc = 4'd7;
        clk_step();
        id = '{default: '0}; id.rd1 = 32'hFFFF_FFFF; id.rd2 = 32'd1; id.aluc = 4'd9;
        clk_step();
        id.aluc = 4'd8;
        n_vec++;
        if (bus.alu_res_EX_MEM_o !== 32'hF800_0000) begin
            n_err++; $display("FAIL sra got %h want f8000000", bus.alu_res_EX_MEM_o);
        end
        clk_step();
        id = '{default: '0};
        n_vec++;
        if (bus.alu_res_EX_MEM_o !== 32'd0) begin
            n_err++; $display("FAIL sltu got %h want 0", bus.alu_res_EX_MEM_o);
        end
        clk_step();
        n_vec++;
        if (bus.alu_res_EX_MEM_o !== 32'd1) begin
            n_err++; $display("FAIL slt got %h want 1", bus.alu_res_EX_MEM_o);
        end
    endtask

    task automatic test_random();
        logic tb, tj;
        logic [31:0] tgt_b, tgt_j, alu, wd;
        logic [82:0]  exp_c;
        logic [139:0] exp_m;
        for (int i = 0; i < 400; i++) begin
            id.pc = $urandom; id.pc4 = id.pc + 4; id.inst = $urandom; id.imm = $urandom;
            id.rd1 = $urandom; id.rd2 = ($urandom_range(0, 3) == 0) ? id.rd1 : $urandom;
            id.rs1 = 5'($urandom); id.rs2 = 5'($urandom); id.rd = 5'($urandom);
            id.rw = 1'($urandom); id.mw = 1'($urandom); id.mb = 1'($urandom);
            id.rsel = 2'($urandom); id.uj = 2'($urandom); id.sa = 2'($urandom);
            id.sb = 2'($urandom); id.aluc = 4'($urandom); id.f3 = 3'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            f1 = 3'($urandom); f2 = 3'($urandom);
            mem_v = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            wb_v = $urandom;
            drive();
            #1;
            model_ex(tb, tj, tgt_b, tgt_j, alu, wd);
            exp_c = {ex_m.rs1, ex_m.rs2, ex_m.rd, ex_m.rsel, tb, tj, tgt_b, tgt_j};
            exp_m = {em_m.inst, em_m.rw, em_m.mw, em_m.rsel, em_m.alu, em_m.rd,
                     em_m.wd, em_m.pc4, em_m.f3};
            n_vec++;
            if (got_ex() !== exp_c) begin
                n_err++; $display("FAIL rand_ex_comb cycle %0d got %h want %h", i, got_ex(), exp_c);
            end
            n_vec++;
            if (got_em() !== exp_m) begin
                n_err++; $display("FAIL rand_exmem cycle %0d got %h want %h", i, got_em(), exp_m);
            end
            clk_step();
        end
    endtask

    task automatic test_mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (got_em() !== 140'd0) begin
            n_err++; $display("FAIL midreset_exmem got %h want 0", got_em());
        end
        n_vec++;
        if (bus.PC_take_branch_EX !== 1'b0 || bus.PC_take_jalr_EX !== 1'b0) begin
            n_err++; $display("FAIL midreset_redirect got br=%b jalr=%b want 0 0",
                              bus.PC_take_branch_EX, bus.PC_take_jalr_EX);
        end
        clear_model();
        @(negedge clk);
        id = '{default: '0}; flush = 0; f1 = 0; f2 = 0;
        clk_step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_branch();
        test_jalr();
        test_flush();
        test_back_to_back_alu();
        test_random();
        test_mid_reset();
        test_add();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I pipeline, bundling three parts:
- the ID/EX pipeline register;
- the EX datapath (operand forwarding, ALU, branch/jump resolution);
- the EX/MEM pipeline register.

It takes decoded fields and control from ID and drives the next-PC selector with branch/jump decisions. It feeds the MEM stage, the hazard unit and the forwarding unit.

## Interface
- INST_WIDTH, 32, instruction width
- INST_ADDR_WIDTH, 32, PC width
- DATA_WIDTH, 32, operand/result width
- DATA_ADDR_WIDTH, 32, data address width
- REGISTER_WIDTH, 32, register width
- REGISTER_ADDR_WIDTH, 5, register index width
- cpu_clk  in  1  single clock, rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- flush_ID_EX  in  1  load a bubble into ID/EX
- PC_ID, PC_plus_4_ID  in  INST_ADDR_WIDTH  PC and PC+4 of the ID instruction
- INST_ID  in  INST_WIDTH  raw instruction
- rs1_ID, rs2_ID, rd_ID  in  REGISTER_ADDR_WIDTH  register indices
- imm_ID  in  DATA_WIDTH  signed immediate
- RD1D_ID, RD2D_ID  in  DATA_WIDTH  register-file read data
- reg_write_ID, mem_write_ID, meet_branch_ID  in  1  control bits
- result_sel_ID  in  2  writeback source: 0 ALU, 1 memory, 2 PC+4
- uncond_jump_ID  in  2  jump type: 0 none, 1 JAL, 2 JALR
- alu_ctrl_ID  in  4  ALU operation
- alu_sel_rs1_ID  in  2  ALU A source: 0 rs1, 1 PC, 2 zero
- alu_sel_rs2_ID  in  2  ALU B source: 0 rs2, 1 imm, 2 constant 4
- funct3_ID  in  3  funct3 field
- forward_detect_EX_rs1, forward_detect_EX_rs2  in  3  forwarding select per operand
- alu_res_EX_MEM_o_fwd  in  DATA_WIDTH  MEM-stage ALU result (forward source)
- result_WB  in  DATA_WIDTH  WB result (forward source)
- rs1_EX, rs2_EX, rd_EX  out  REGISTER_ADDR_WIDTH  EX-stage indices, combinational
- result_sel_EX  out  2  EX-stage writeback source, combinational
- PC_take_branch_EX, PC_take_jalr_EX  out  1  redirect requests, combinational
- PC_for_normal_branch_EX, PC_for_jalr_EX  out  INST_ADDR_WIDTH  redirect targets, combinational
- EX/MEM register outputs, all registered:
  - INST_EX_MEM_o
  - reg_write_EX_MEM_o, mem_write_EX_MEM_o
  - result_sel_EX_MEM_o
  - alu_res_EX_MEM_o
  - rd_EX_MEM_o
  - write_data_EX_MEM_o
  - PC_plus_4_EX_MEM_o
  - funct3_EX_MEM_o

## Operation
- **ID/EX register:** captures every ID input each edge.
- **Flush:** when flush_ID_EX=1, every ID/EX field loads 0, which is a NOP (reg_write=0, mem_write=0, no branch or jump).
- **Forwarding:** applies independently to rs1 and rs2.
  - Select 1: use alu_res_EX_MEM_o_fwd.
  - Select 2: use result_WB.
  - Any other value: use the registered RD1D/RD2D.
- **Operand muxes:** A and B are chosen by alu_sel_rs1 and alu_sel_rs2. Code 3 selects 0.
- **ALU codes:**
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 sll, 6 srl, 7 sra (all shift by B[4:0])
  - 8 slt (signed), 9 sltu
  - 10 pass B
  - any other code gives 0
  - Arithmetic wraps modulo 2^DATA_WIDTH.
- **Conditional branch:** evaluated only when meet_branch=1, comparing forwarded rs1 against forwarded rs2 by funct3:
  - 0 eq, 1 ne
  - 4 lt signed, 5 ge signed
  - 6 lt unsigned, 7 ge unsigned
  - codes 2 and 3 are never taken
- **Branch/jump outputs:**
  - PC_take_branch_EX = (meet_branch & condition) | (uncond_jump==1).
  - PC_for_normal_branch_EX = PC + imm.
  - PC_take_jalr_EX = (uncond_jump==2).
  - PC_for_jalr_EX = (forwarded rs1 + imm) with bit 0 cleared.
- **EX/MEM data:** write_data_EX = forwarded rs2. rd, control, INST, PC+4 and funct3 pass through unchanged.
- **EX/MEM register:** loads every edge; it has no stall and no flush.

## Timing
- Reset (asynchronous assert): both registers clear to all-zero. Every registered output is 0 and the combinational branch outputs are inactive.
- Latency:
  - ID inputs reach EX combinational outputs 1 edge later.
  - ID inputs reach EX/MEM outputs 2 edges later.
- Flush and valid data at the same edge: flush wins.
- Forward select, forward data and EX outputs are purely combinational within the cycle.

## Configuration
- EX_RS2_FWD_EN
  - Defined: rs2 forwarding as described.
  - Undefined: forward_detect_EX_rs2 is ignored and rs2 always uses the registered RD2D, for both ALU B and store data. rs1 forwarding is unaffected.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU op codes
  - ALU source selects
  - result_sel and uncond_jump encodings
  - forward-select values
  - branch funct3 values
- One natural sub-module: `alu` (A, B, ctrl → result). Registers and muxes live in ex_stage.

## Test plan
- ADD after reset: rs1 data 5, rs2 data 7, alu_ctrl 0, sel 0/0 → alu_res_EX_MEM_o = 12 two edges later; reset low mid-run → all outputs 0.
- Forwarding: forward_detect_EX_rs1=1 with MEM value 0x100, and forward_detect_EX_rs2=2 with WB value 3, sub → alu_res 0xFD. Without EX_RS2_FWD_EN, the same case with RD2D 1 → 0xFF.
- BLT signed: rs1=-1, rs2=1, funct3 4, meet_branch, PC 0x40, imm 8 → PC_take_branch_EX=1, target 0x48. BLTU with the same operands → not taken.
- JALR: rs1=0x1001, imm 4, uncond_jump 2 → PC_take_jalr_EX=1, PC_for_jalr_EX=0x1004, PC_plus_4 carried to EX/MEM.
- Flush: flush_ID_EX=1 with a store (mem_write=1) at ID → EX/MEM mem_write and reg_write stay 0.
- SRA: A=0x80000000, B=4, ctrl 7 → 0xF8000000. SLTU with 0xFFFFFFFF vs 1 → 0.
